mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `shift_add_multiplier` instance among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and starts the multiplier by pulsing its load/reset input. It waits for the multiplier's done flag and returns the 2W-bit product to the granted requester. A watchdog flags a multiplication that never completes.

---
 rtl/mult_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier among N_REQ requesters,
// with a watchdog that turns a multiplication that never finishes into an error response.
module mult_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned W       = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*W-1:0]   req_b,
   input  logic [N_REQ*W-1:0]   req_q,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [2*W-1:0]       rsp_result,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 mul_load,
   output logic [W-1:0]         mul_b,
   output logic [W-1:0]         mul_q,
   input  logic [2*W-1:0]       mul_result,
   input  logic                 mul_done
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_BUSY, S_RESP} state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      last_q, last_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [W-1:0]         mul_b_q, mul_b_d;
   logic [W-1:0]         mul_q_q, mul_q_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [2*W-1:0]       rsp_result_q, rsp_result_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 busy_q, busy_d;
   logic                 mul_load_q, mul_load_d;

   logic [W-1:0]         b_arr [N_REQ];
   logic [W-1:0]         q_arr [N_REQ];
   logic [ID_W-1:0]      idx;
   logic [ID_W-1:0]      win_id;
   logic                 win_found;

   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) begin
         b_arr[i] = req_b[i*W +: W];
         q_arr[i] = req_q[i*W +: W];
      end
   end

   // Scan downward in rotation distance so the nearest valid requester after last_q wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         idx = ID_W'((32'(last_q) + 32'(k)) % N_REQ);
         if (req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      mul_b_d      = mul_b_q;
      mul_q_d      = mul_q_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      req_ready    = '0;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               req_ready[win_id] = 1'b1;
               mul_b_d           = b_arr[win_id];
               mul_q_d           = q_arr[win_id];
               last_d            = win_id;
               id_d              = win_id;
               state_d           = S_LOAD;
            end
         end
         S_LOAD: state_d = S_SETTLE;
         // mul_done may still be high from the previous product here.
         S_SETTLE: begin
            cnt_d   = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (mul_done) begin
               rsp_result_d      = mul_result;
               rsp_err_d         = 1'b0;
               rsp_valid_d[id_q] = 1'b1;
               state_d           = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_result_d      = '0;
               rsp_err_d         = 1'b1;
               rsp_valid_d[id_q] = 1'b1;
               state_d           = S_RESP;
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         S_RESP: begin
            if (rsp_ready[id_q]) begin
               rsp_valid_d = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      mul_load_d = (state_d == S_LOAD);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         last_q       <= ID_W'(N_REQ - 1);
         id_q         <= '0;
         mul_b_q      <= '0;
         mul_q_q      <= '0;
         cnt_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         mul_load_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         id_q         <= id_d;
         mul_b_q      <= mul_b_d;
         mul_q_q      <= mul_q_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
         mul_load_q   <= mul_load_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = busy_q;
   assign mul_load   = mul_load_q;
   assign mul_b      = mul_b_q;
   assign mul_q      = mul_q_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier with programmable latency plus a
// round-robin reference model tracking pending requests and expected products.
module tb_mult_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int TMO = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_b;
   logic [N*W-1:0]   req_q;
   logic [N-1:0]     rsp_valid;
   logic [N-1:0]     rsp_ready;
   logic [2*W-1:0]   rsp_result;
   logic             rsp_err;
   logic             busy;
   logic             mul_load;
   logic [W-1:0]     mul_b;
   logic [W-1:0]     mul_q;
   logic [2*W-1:0]   mul_result;
   logic             mul_done;

   mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_b(req_b), .req_q(req_q),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .busy(busy), .mul_load(mul_load),
      .mul_b(mul_b), .mul_q(mul_q),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   // Multiplier model: done clears one cycle after load, so it is stale during SETTLE.
   logic        m_load_d = 1'b0;
   int          m_cnt    = 0;
   logic        m_done   = 1'b0;
   logic [15:0] m_res    = '0;
   int          m_lat    = 3;
   bit          tie_low  = 1'b0;

   always @(posedge clk) begin
      m_load_d <= mul_load;
      if (m_load_d) begin
         m_cnt  <= m_lat;
         m_done <= 1'b0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_res  <= 16'(mul_b) * 16'(mul_q);
         end
      end
   end

   assign mul_done   = m_done & ~tie_low;
   assign mul_result = m_res;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model state
   logic [N-1:0] pend;
   logic [7:0]   rb [N];
   logic [7:0]   rq [N];
   int           rlast;

   function automatic int rr_pick(input logic [N-1:0] p, input int last);
      for (int k = 1; k <= N; k++)
         if (p[(last + k) % N]) return (last + k) % N;
      return 0;
   endfunction

   task automatic post(input int i, input logic [7:0] b, input logic [7:0] q);
      pend[i]          = 1'b1;
      rb[i]            = b;
      rq[i]            = q;
      req_b[i*W +: W]  = b;
      req_q[i*W +: W]  = q;
      req_valid[i]     = 1'b1;
   endtask

   // Called at a negedge with DUT in IDLE; runs one full transaction.
   task automatic serve(input int bp, input bit tmo);
      int           id, n, loads, bad;
      logic [15:0]  er;
      logic [N-1:0] oh;
      id = rr_pick(pend, rlast);
      oh = N'(1) << id;
      er = tmo ? 16'd0 : 16'(rb[id]) * 16'(rq[id]);
      #1;
      n = 0;
      while (req_ready == '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 32'(req_ready), 32'(oh));
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      pend[id]      = 1'b0;
      rlast         = id;
      n = 0; loads = 0; bad = 0;
      do begin
         @(negedge clk);
         n++;
         if (mul_load) loads++;
         if (req_ready != '0) bad++;
      end while (!rsp_valid[id] && n < 200);
      chk("latency", 32'(n), tmo ? 32'(3 + TMO) : 32'(4 + m_lat));
      chk("load_pulses", 32'(loads), 32'd1);
      chk("operands", {16'd0, mul_b, mul_q}, {16'd0, rb[id], rq[id]});
      chk("rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_result", 32'(rsp_result), 32'(er));
      chk("rsp_err", 32'(rsp_err), 32'(tmo));
      chk("busy", 32'(busy), 32'd1);
      for (int k = 0; k < bp; k++) begin
         rsp_ready = N'($urandom) & ~oh;
         @(negedge clk);
         if (rsp_valid !== oh || rsp_result !== er || rsp_err !== tmo || req_ready != '0) bad++;
      end
      chk("hold_and_no_ready", 32'(bad), 32'd0);
      rsp_ready = N'($urandom) | oh;
      @(posedge clk);
      #1 rsp_ready = '0;
      @(negedge clk);
      chk("released", {30'd0, busy, |rsp_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; req_valid = '0; req_b = '0; req_q = '0; rsp_ready = '0;
      pend = '0; rlast = N - 1;
      for (int i = 0; i < N; i++) begin rb[i] = '0; rq[i] = '0; end
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", 32'(rsp_result), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mul_load", 32'(mul_load), 32'd1);
      chk("rst_mul_ops", {16'd0, mul_b, mul_q}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_mul_load", 32'(mul_load), 32'd0);

      // Single request
      m_lat = 4;
      post(0, 8'd5, 8'd3);
      serve(0, 1'b0);

      // Contention
      post(1, 8'd12, 8'd10);
      post(2, 8'd201, 8'd127);
      m_lat = 6;
      serve(1, 1'b0);
      serve(0, 1'b0);

      // Fairness: all requesters re-request 255x255 after every response
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i]) post(i, 8'd255, 8'd255);
         m_lat = 2 + r;
         serve(0, 1'b0);
      end
      while (pend != '0) serve(0, 1'b0);

      // Backpressure
      m_lat = 3;
      post(0, 8'($urandom), 8'($urandom));
      serve(10, 1'b0);

      // Timeout, then the next request is served normally
      tie_low = 1'b1;
      post(3, 8'd7, 8'd9);
      post(1, 8'd11, 8'd13);
      serve(2, 1'b1);
      tie_low = 1'b0;
      m_lat = 5;
      serve(0, 1'b0);

      // Random traffic
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && ($urandom_range(0, 1) == 1)) post(i, 8'($urandom), 8'($urandom));
         m_lat = $urandom_range(1, 20);
         if (pend != '0) serve($urandom_range(0, 3), 1'b0);
      end
      while (pend != '0) serve(0, 1'b0);

      // Reset abort during BUSY
      m_lat = 30;
      post(2, 8'd9, 8'd9);
      repeat (5) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      #2;
      rst = 1'b0;
      req_valid = '0;
      #1;
      chk("abort_mul_load", 32'(mul_load), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_mul_ops", {16'd0, mul_b, mul_q}, 32'd0);
      pend = '0;
      rlast = N - 1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      m_lat = 5;
      post(2, 8'd16, 8'd16);
      serve(0, 1'b0);
      chk("abort_product", 32'(16'(rb[2]) * 16'(rq[2])), 32'd256);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
